// File: rtl/pc_pkg.sv
// Shared defaults and the operation type for the fetch PC / return-address-stack unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pc_pkg;

    localparam int PC_W_DEF      = 18;
    localparam int STEP_DEF      = 1;
    localparam int RESET_VEC_DEF = 0;

    // One operation per cycle, chosen by the fixed-priority decode in pc_ras_unit.
    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_BR,
        OP_LD,
        OP_CALL,
        OP_RET
    } op_t;

endpackage

// File: rtl/ras_stack.sv
// Circular LIFO of return addresses; a push when full overwrites the oldest entry.
// Latency: push/pop take effect on the next edge; topDat is read combinationally from wptr-1.
// Backpressure: none -- overflow/underflow are reported as single-cycle event pulses.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 18,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clr,
    input  logic [W-1:0]  pushDat,
    output logic [W-1:0]  topDat,
    output logic [PW:0]   cnt,
    output logic          full,
    output logic          empty,
    output logic          ovfEvt,
    output logic          udfEvt
);

    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_ONE = 1;
    localparam logic [PW:0]   CNT_MAX = DEPTH[PW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rdPtr;
    logic          doPush;
    logic          doPop;

    assign rdPtr  = wptr - PTR_ONE;
    assign topDat = mem[rdPtr];
    assign full   = (cnt == CNT_MAX);
    assign empty  = (cnt == '0);

    // Pop wins if both are requested; the caller is expected to never ask for both.
    assign doPop  = pop & ~empty;
    assign doPush = push & ~pop & ~clr;
    assign ovfEvt = doPush & full;
    assign udfEvt = pop & empty & ~clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            cnt  <= '0;
        end else if (clr) begin
            wptr <= '0;
            cnt  <= '0;
        end else if (doPop) begin
            wptr <= rdPtr;
            cnt  <= cnt - CNT_ONE;
        end else if (doPush) begin
            wptr <= wptr + PTR_ONE;
            if (!full) begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wptr] <= pushDat;
        end
    end

endmodule

// File: rtl/pc_ras_unit.sv
// Fetch PC register with step/load/branch/call/return and sticky RAS overflow/underflow flags.
// Latency: 1 cycle from strobe to PCout and flags; PCout is always a flop.
// Backpressure: stall freezes all state; one operation per cycle, ret > call > wr > br > re.
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int          PC_W      = PC_W_DEF,
    parameter int          STEP      = STEP_DEF,
    parameter int          RAS_DEPTH = 4,
    parameter int unsigned RESET_VEC = RESET_VEC_DEF,
    localparam int         CW        = $clog2(RAS_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            re_PC,
    input  logic            wr_PC,
    input  logic            br_PC,
    input  logic            call,
    input  logic            ret,
    input  logic            clr_err,
    input  logic [PC_W-1:0] PCin,
    input  logic [PC_W-1:0] br_off,
    output logic [PC_W-1:0] PCout,
    output logic [CW-1:0]   ras_cnt,
    output logic            ras_full,
    output logic            ras_empty,
    output logic            ras_ovf,
    output logic            ras_udf
);

    localparam logic [PC_W-1:0] STEP_V  = PC_W'(STEP);
    localparam logic [PC_W-1:0] RST_PC  = PC_W'(RESET_VEC);

    op_t             op;
    logic [PC_W-1:0] pcPlusStep;
    logic [PC_W-1:0] pcNext;
    logic [PC_W-1:0] rasTop;
    logic            ovfEvt;
    logic            udfEvt;

    assign pcPlusStep = PCout + STEP_V;

    always_comb begin
        op = OP_HOLD;
        if (!stall) begin
            if (ret)        op = OP_RET;
            else if (call)  op = OP_CALL;
            else if (wr_PC) op = OP_LD;
            else if (br_PC) op = OP_BR;
            else if (re_PC) op = OP_INC;
        end
    end

    // br_off is already PC_W wide, so a plain add is the sign-extended, wrapping branch.
    always_comb begin
        pcNext = PCout;
        case (op)
            OP_INC:  pcNext = pcPlusStep;
            OP_BR:   pcNext = PCout + br_off;
            OP_LD:   pcNext = PCin;
            OP_CALL: pcNext = PCin;
            OP_RET:  pcNext = ras_empty ? pcPlusStep : rasTop;
            default: pcNext = PCout;
        endcase
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push    (op == OP_CALL),
        .pop     (op == OP_RET),
        .clr     (1'b0),
        .pushDat (pcPlusStep),
        .topDat  (rasTop),
        .cnt     (ras_cnt),
        .full    (ras_full),
        .empty   (ras_empty),
        .ovfEvt  (ovfEvt),
        .udfEvt  (udfEvt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PCout   <= RST_PC;
            ras_ovf <= 1'b0;
            ras_udf <= 1'b0;
        end else begin
            PCout <= pcNext;
            // A new event on the clearing edge takes precedence over the clear.
            if (!stall) begin
                ras_ovf <= (ras_ovf & ~clr_err) | ovfEvt;
                ras_udf <= (ras_udf & ~clr_err) | udfEvt;
            end
        end
    end

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed vector table, random stimulus against a queue-based model, and an async-reset corner.
module tb_pc_ras_unit;

    localparam int PC_W  = 18;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            stall = 1'b0, re_PC = 1'b0, wr_PC = 1'b0, br_PC = 1'b0;
    logic            call = 1'b0, ret = 1'b0, clr_err = 1'b0;
    logic [PC_W-1:0] PCin = '0, br_off = '0;
    logic [PC_W-1:0] PCout;
    logic [2:0]      ras_cnt;
    logic            ras_full, ras_empty, ras_ovf, ras_udf;

    int nCmp = 0;
    int nErr = 0;

    pc_ras_unit #(.PC_W(PC_W), .STEP(1), .RAS_DEPTH(DEPTH), .RESET_VEC(0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .re_PC(re_PC), .wr_PC(wr_PC), .br_PC(br_PC),
        .call(call), .ret(ret), .clr_err(clr_err), .PCin(PCin), .br_off(br_off),
        .PCout(PCout), .ras_cnt(ras_cnt), .ras_full(ras_full), .ras_empty(ras_empty),
        .ras_ovf(ras_ovf), .ras_udf(ras_udf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            stall, re, wr, br, cl, rt, clr;
        logic [PC_W-1:0] pcIn, off;
        logic [PC_W-1:0] expPc;
        int              expCnt;
        logic            expOvf, expUdf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkAll(input string tag, input logic [PC_W-1:0] pc, input int cnt,
                          input logic ovf, input logic udf);
        chk({tag, ".PCout"}, 32'(PCout), 32'(pc));
        chk({tag, ".ras_cnt"}, 32'(ras_cnt), 32'(cnt));
        chk({tag, ".ras_full"}, 32'(ras_full), 32'(cnt == DEPTH));
        chk({tag, ".ras_empty"}, 32'(ras_empty), 32'(cnt == 0));
        chk({tag, ".ras_ovf"}, 32'(ras_ovf), 32'(ovf));
        chk({tag, ".ras_udf"}, 32'(ras_udf), 32'(udf));
    endtask

    task automatic drive(input logic s, input logic r, input logic w, input logic b,
                         input logic c, input logic t, input logic e,
                         input logic [PC_W-1:0] pi, input logic [PC_W-1:0] o);
        stall = s; re_PC = r; wr_PC = w; br_PC = b; call = c; ret = t; clr_err = e;
        PCin = pi; br_off = o;
    endtask

    task automatic doReset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    // Behavioural reference: PC plus a queue where back is the most recent return address.
    logic [PC_W-1:0] mPc;
    logic [PC_W-1:0] mQ[$];
    logic            mOvf, mUdf;

    task automatic modelStep();
        if (stall) return;
        if (clr_err) begin mOvf = 1'b0; mUdf = 1'b0; end
        if (ret) begin
            if (mQ.size() > 0) mPc = mQ.pop_back();
            else begin mPc = mPc + 1'b1; mUdf = 1'b1; end
        end else if (call) begin
            if (mQ.size() == DEPTH) begin void'(mQ.pop_front()); mOvf = 1'b1; end
            mQ.push_back(mPc + 1'b1);
            mPc = PCin;
        end else if (wr_PC) mPc = PCin;
        else if (br_PC) mPc = mPc + br_off;
        else if (re_PC) mPc = mPc + 1'b1;
    endtask

    vec_t vt[$];

    initial begin
        // stall re wr br call ret clr pcIn off | expPc cnt ovf udf
        vt.push_back('{0,1,0,0,0,0,0, 18'h0,     18'h0,     18'h1,     0,0,0});
        vt.push_back('{0,1,0,0,0,0,0, 18'h0,     18'h0,     18'h2,     0,0,0});
        vt.push_back('{0,1,0,0,0,0,0, 18'h0,     18'h0,     18'h3,     0,0,0});
        vt.push_back('{0,0,1,0,0,0,0, 18'h3FFFF, 18'h0,     18'h3FFFF, 0,0,0});
        vt.push_back('{0,1,0,0,0,0,0, 18'h0,     18'h0,     18'h0,     0,0,0});
        vt.push_back('{0,0,0,1,0,0,0, 18'h0,     18'h3FFFE, 18'h3FFFE, 0,0,0});
        vt.push_back('{0,0,1,0,0,0,0, 18'h10,    18'h0,     18'h10,    0,0,0});
        vt.push_back('{0,0,0,0,1,0,0, 18'h100,   18'h0,     18'h100,   1,0,0});
        vt.push_back('{0,0,0,0,1,0,0, 18'h200,   18'h0,     18'h200,   2,0,0});
        vt.push_back('{0,0,0,0,0,1,0, 18'h0,     18'h0,     18'h101,   1,0,0});
        vt.push_back('{0,0,0,0,0,1,0, 18'h0,     18'h0,     18'h11,    0,0,0});
        vt.push_back('{0,0,1,0,0,0,0, 18'h0,     18'h0,     18'h0,     0,0,0});
        vt.push_back('{0,0,0,0,1,0,0, 18'h1,     18'h0,     18'h1,     1,0,0});
        vt.push_back('{0,0,0,0,1,0,0, 18'h2,     18'h0,     18'h2,     2,0,0});
        vt.push_back('{0,0,0,0,1,0,0, 18'h3,     18'h0,     18'h3,     3,0,0});
        vt.push_back('{0,0,0,0,1,0,0, 18'h4,     18'h0,     18'h4,     4,0,0});
        vt.push_back('{0,0,0,0,1,0,0, 18'h5,     18'h0,     18'h5,     4,1,0});
        vt.push_back('{0,0,0,0,0,1,0, 18'h0,     18'h0,     18'h5,     3,1,0});
        vt.push_back('{0,0,0,0,0,1,0, 18'h0,     18'h0,     18'h4,     2,1,0});
        vt.push_back('{0,0,0,0,0,1,0, 18'h0,     18'h0,     18'h3,     1,1,0});
        vt.push_back('{0,0,0,0,0,1,0, 18'h0,     18'h0,     18'h2,     0,1,0});
        vt.push_back('{0,0,0,0,0,1,0, 18'h0,     18'h0,     18'h3,     0,1,1});
        vt.push_back('{0,0,0,0,0,0,1, 18'h0,     18'h0,     18'h3,     0,0,0});
        vt.push_back('{0,0,0,0,1,0,0, 18'h40,    18'h0,     18'h40,    1,0,0});
        vt.push_back('{0,1,0,0,1,1,0, 18'h77,    18'h0,     18'h4,     0,0,0});
        vt.push_back('{1,0,1,0,0,0,0, 18'h55,    18'h0,     18'h4,     0,0,0});
        vt.push_back('{0,0,0,0,0,1,0, 18'h0,     18'h0,     18'h5,     0,0,1});
        vt.push_back('{1,0,1,0,0,0,1, 18'h55,    18'h0,     18'h5,     0,0,1});
        vt.push_back('{0,0,1,0,0,0,0, 18'h55,    18'h0,     18'h55,    0,0,1});
        vt.push_back('{0,0,0,0,0,1,1, 18'h0,     18'h0,     18'h56,    0,0,1});
        vt.push_back('{0,0,0,0,0,0,1, 18'h0,     18'h0,     18'h56,    0,0,0});

        #3;
        chkAll("reset", '0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        foreach (vt[i]) begin
            drive(vt[i].stall, vt[i].re, vt[i].wr, vt[i].br, vt[i].cl, vt[i].rt, vt[i].clr,
                  vt[i].pcIn, vt[i].off);
            @(posedge clk);
            #1;
            chkAll($sformatf("vec%0d", i), vt[i].expPc, vt[i].expCnt, vt[i].expOvf, vt[i].expUdf);
        end

        // Random phase against the model.
        drive(0, 0, 0, 0, 0, 0, 0, '0, '0);
        doReset();
        mPc = '0; mQ.delete(); mOvf = 1'b0; mUdf = 1'b0;
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0,
                  PC_W'($urandom), PC_W'($urandom));
            modelStep();
            @(posedge clk);
            #1;
            chkAll($sformatf("rnd%0d", k), mPc, mQ.size(), mOvf, mUdf);
        end

        // Async reset in the middle of a call cycle.
        drive(0, 0, 0, 0, 1, 0, 0, 18'h123, '0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 1, 0, 0, 18'h124, '0);
        #3;
        rst = 1'b0;
        #1;
        chkAll("arst_immediate", '0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chkAll("arst_held", '0, 0, 1'b0, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, '0, '0);
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
- Parametrised successor to the fixed 18-bit program counter.
- Holds the fetch PC and supports:
  - sequential advance by a configurable step
  - absolute load
  - signed relative branch
  - call/return through an internal return-address stack (RAS) with overflow/underflow reporting
- Sits between the fetch stage and the branch/decode logic; PCout feeds the instruction-memory address.

Parameters:
- PC_W, 18: PC width in bits; all PC arithmetic is modulo 2^PC_W.
- STEP, 1: increment applied on a sequential advance and used to form the return address.
- RAS_DEPTH, 4: number of RAS entries; must be a power of two, >= 2.
- RESET_VEC, 0: PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  freeze all state; overrides every other strobe.
- re_PC  in  1  sequential advance (fetch consumed).
- wr_PC  in  1  absolute load from PCin.
- br_PC  in  1  relative branch: PC + br_off.
- call  in  1  push return address, then jump to PCin.
- ret  in  1  pop RAS into PC.
- clr_err  in  1  clear the sticky error flags.
- PCin  in  PC_W  absolute target for wr_PC and call.
- br_off  in  PC_W  signed two's-complement branch offset.
- PCout  out  PC_W  current PC register value.
- ras_cnt  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
- ras_full  out  1  ras_cnt == RAS_DEPTH.
- ras_empty  out  1  ras_cnt == 0.
- ras_ovf  out  1  sticky: a call occurred while the RAS was full.
- ras_udf  out  1  sticky: a ret occurred while the RAS was empty.

Behaviour:
- Reset (rst=0, asynchronous):
  - PCout=RESET_VEC, ras_cnt=0, ras_empty=1, ras_full=0, ras_ovf=0, ras_udf=0.
  - RAS contents are don't-care.
  - Reset asserted mid-operation aborts that operation; no partial push or pop survives.
- All updates are registered; a strobe sampled at edge N is visible on PCout and the flags after edge N (latency 1). PCout is a flop, never combinational from the inputs.
- stall=1: no state changes. clr_err is ignored while stall=1.
- With stall=0, exactly one operation is taken per cycle, in fixed priority ret > call > wr_PC > br_PC > re_PC. No strobe asserted: hold.
- re_PC: PC <= PC + STEP, wrapping modulo 2^PC_W.
- br_PC: PC <= PC + br_off, with br_off sign-extended to PC_W; wraps modulo 2^PC_W.
- wr_PC: PC <= PCin.
- call:
  - RAS[top] <= PC + STEP (wrapped); PC <= PCin.
  - If not full: ras_cnt increments.
  - If full: the oldest entry is overwritten (circular), ras_cnt stays RAS_DEPTH, ras_ovf <= 1.
- ret:
  - If not empty: PC <= most recent entry; ras_cnt decrements.
  - If empty: PC <= PC + STEP, ras_cnt stays 0, ras_udf <= 1.
- RAS implementation:
  - Circular buffer with a write pointer of $clog2(RAS_DEPTH) bits that wraps.
  - Push writes at wptr, then wptr+1. Pop reads wptr-1, then wptr-1.
- call and ret asserted together: only ret is taken; call is dropped and no push occurs.
- clr_err=1 with stall=0 clears ras_ovf and ras_udf on the same edge. If a new ovf/udf event happens on that same edge, the set wins.
- ras_full and ras_empty are decoded from the registered ras_cnt.

Decomposition:
- Shared package pc_pkg:
  - default PC_W, STEP, RESET_VEC constants
  - an enumerated operation type (OP_HOLD, OP_INC, OP_BR, OP_LD, OP_CALL, OP_RET), produced by the priority decode
- One natural sub-module, ras_stack: circular LIFO with push/pop/clr inputs, top-of-stack data out, count and full/empty outputs, and ovf/udf event pulses. Parameters DEPTH and W.
- pc_ras_unit owns the priority decode, the PC register, and the sticky flags.

Test Plan:
- Reset and advance: rst=0 then 1, re_PC=1 for 3 cycles -> PCout 0,1,2,3; flags all 0, ras_empty=1.
- Wrap: wr_PC with PCin=18'h3FFFF, then re_PC -> PCout 18'h3FFFF then 18'h00000. Then br_PC with br_off=-2 (18'h3FFFE) -> PCout 18'h3FFFE.
- Call/return nest:
  - PC=0x10: call PCin=0x100 -> PCout=0x100, ras_cnt=1.
  - call PCin=0x200 -> ras_cnt=2.
  - ret -> PCout=0x101.
  - ret -> PCout=0x11, ras_empty=1.
- Overflow/underflow (RAS_DEPTH=4):
  - Five calls from PCs 0,1,2,3,4 -> ras_ovf=1, ras_cnt=4.
  - Four rets return 5,4,3,2; a fifth ret -> PC+1 and ras_udf=1.
  - clr_err -> both flags 0.
- Priority and stall:
  - ret+call+re_PC together -> only the pop occurs.
  - stall=1 with wr_PC PCin=0x55 -> PCout unchanged.
  - Releasing stall with wr_PC held -> PCout=0x55 next cycle.
- Async reset mid-call: drop rst between edges while call=1 -> PCout=RESET_VEC and ras_cnt=0 immediately, without waiting for a clock edge.
